// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the conv layer sequencer: default widths, FSM states, o_state codes.
package conv_layer_sequencer_pkg;

  localparam int unsigned LAYER_W_DEF = 2;
  localparam int unsigned CH_W_DEF    = 6;
  localparam int unsigned ROW_W_DEF   = 8;
  localparam int unsigned STATE_W     = 2;

  // Internal sequencing states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_PARAM = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } fsm_t;

  // Externally visible phase code broadcast to in_buffer and conv
  typedef enum logic [STATE_W-1:0] {
    OST_IDLE  = 2'd0,
    OST_LOAD  = 2'd1,
    OST_RUN   = 2'd2,
    OST_DRAIN = 2'd3
  } ostate_t;

endpackage

// File: rtl/conv_layer_sequencer.sv
// Hardware layer -> oc -> ic loop for the conv accelerator; requests config/params and tracks rows/drain.
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int unsigned LAYER_W = LAYER_W_DEF,
  parameter int unsigned CH_W    = CH_W_DEF,
  parameter int unsigned ROW_W   = ROW_W_DEF
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [LAYER_W-1:0] i_num_layers,
  output logic               o_cfg_req,
  input  logic               i_cfg_valid,
  input  logic [CH_W-1:0]    i_cfg_ic_last,
  input  logic [CH_W-1:0]    i_cfg_oc_last,
  input  logic [ROW_W-1:0]   i_cfg_row_last,
  output logic               o_param_req,
  input  logic               i_params_valid,
  input  logic               i_row_done,
  input  logic               i_send_done,
  output logic [STATE_W-1:0] o_state,
  output logic [LAYER_W-1:0] o_current_layer,
  output logic [CH_W-1:0]    o_current_ic,
  output logic [CH_W-1:0]    o_current_oc,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  fsm_t               state;
  logic [LAYER_W-1:0] num_layers;
  logic [CH_W-1:0]    ic_last;
  logic [CH_W-1:0]    oc_last;
  logic [ROW_W-1:0]   row_last;
  logic [ROW_W-1:0]   row_cnt;
  logic               stray_pulse;

  // Row pulses are legal while running or draining; send pulses only while draining
  always_comb begin
    stray_pulse = 1'b0;
    if (i_row_done && !(state == S_RUN || state == S_DRAIN)) stray_pulse = 1'b1;
    if (i_send_done && state != S_DRAIN)                     stray_pulse = 1'b1;
  end

  // Sequencer FSM with nested layer/oc/ic/row counters and registered outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= S_IDLE;
      num_layers      <= '0;
      ic_last         <= '0;
      oc_last         <= '0;
      row_last        <= '0;
      row_cnt         <= '0;
      o_cfg_req       <= 1'b0;
      o_param_req     <= 1'b0;
      o_state         <= OST_IDLE;
      o_current_layer <= '0;
      o_current_ic    <= '0;
      o_current_oc    <= '0;
      o_valid         <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;

      if (i_abort) begin
        state           <= S_IDLE;
        o_state         <= OST_IDLE;
        o_busy          <= 1'b0;
        o_cfg_req       <= 1'b0;
        o_param_req     <= 1'b0;
        o_current_layer <= '0;
        o_current_ic    <= '0;
        o_current_oc    <= '0;
        row_cnt         <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              state           <= S_CFG;
              o_state         <= OST_LOAD;
              o_busy          <= 1'b1;
              o_cfg_req       <= 1'b1;
              o_current_layer <= '0;
              o_current_ic    <= '0;
              o_current_oc    <= '0;
              row_cnt         <= '0;
              num_layers      <= i_num_layers;
              o_err           <= 1'b0;
            end
          end

          S_CFG: begin
            if (o_cfg_req && i_cfg_valid) begin
              ic_last     <= i_cfg_ic_last;
              oc_last     <= i_cfg_oc_last;
              row_last    <= i_cfg_row_last;
              o_cfg_req   <= 1'b0;
              o_param_req <= 1'b1;
              state       <= S_PARAM;
            end
          end

          S_PARAM: begin
            if (i_params_valid) begin
              o_param_req <= 1'b0;
              o_valid     <= 1'b1;
              o_state     <= OST_RUN;
              state       <= S_RUN;
            end
          end

          S_RUN: begin
            if (i_row_done) begin
              if (row_cnt == row_last) begin
                row_cnt <= '0;
                if (o_current_ic < ic_last) begin
                  o_current_ic <= o_current_ic + CH_W'(1);
                  o_param_req  <= 1'b1;
                  o_state      <= OST_LOAD;
                  state        <= S_PARAM;
                end else begin
                  o_state <= OST_DRAIN;
                  state   <= S_DRAIN;
                end
              end else begin
                row_cnt <= row_cnt + ROW_W'(1);
              end
            end
          end

          S_DRAIN: begin
            if (i_send_done) begin
              o_current_ic <= '0;
              if (o_current_oc < oc_last) begin
                o_current_oc <= o_current_oc + CH_W'(1);
                o_param_req  <= 1'b1;
                o_state      <= OST_LOAD;
                state        <= S_PARAM;
              end else begin
                o_current_oc <= '0;
                if (o_current_layer < num_layers) begin
                  o_current_layer <= o_current_layer + LAYER_W'(1);
                  o_cfg_req       <= 1'b1;
                  o_state         <= OST_LOAD;
                  state           <= S_CFG;
                end else begin
                  o_done <= 1'b1;
                  state  <= S_DONE;
                end
              end
            end
          end

          S_DONE: begin
            o_state <= OST_IDLE;
            o_busy  <= 1'b0;
            state   <= S_IDLE;
          end

          default: begin
            o_state <= OST_IDLE;
            o_busy  <= 1'b0;
            state   <= S_IDLE;
          end
        endcase
      end

      // Misplaced completion pulses latch the error, even over a same-cycle start
      if (stray_pulse) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer with a nested-loop tuple model and per-cycle compare.
module tb_conv_layer_sequencer;
  import conv_layer_sequencer_pkg::*;

  localparam int unsigned LW = LAYER_W_DEF;
  localparam int unsigned CW = CH_W_DEF;
  localparam int unsigned RW = ROW_W_DEF;
  localparam int unsigned TW = LW + 2 * CW;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [LW-1:0] i_num_layers = '0;
  logic          o_cfg_req;
  logic          i_cfg_valid = 1'b0;
  logic [CW-1:0] i_cfg_ic_last = '0;
  logic [CW-1:0] i_cfg_oc_last = '0;
  logic [RW-1:0] i_cfg_row_last = '0;
  logic          o_param_req;
  logic          i_params_valid = 1'b0;
  logic          i_row_done = 1'b0;
  logic          i_send_done = 1'b0;
  logic [1:0]    o_state;
  logic [LW-1:0] o_current_layer;
  logic [CW-1:0] o_current_ic;
  logic [CW-1:0] o_current_oc;
  logic          o_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  conv_layer_sequencer dut (
    .aclk(aclk), .areset(areset), .i_start(i_start), .i_abort(i_abort),
    .i_num_layers(i_num_layers), .o_cfg_req(o_cfg_req), .i_cfg_valid(i_cfg_valid),
    .i_cfg_ic_last(i_cfg_ic_last), .i_cfg_oc_last(i_cfg_oc_last), .i_cfg_row_last(i_cfg_row_last),
    .o_param_req(o_param_req), .i_params_valid(i_params_valid), .i_row_done(i_row_done),
    .i_send_done(i_send_done), .o_state(o_state), .o_current_layer(o_current_layer),
    .o_current_ic(o_current_ic), .o_current_oc(o_current_oc), .o_valid(o_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 aclk = ~aclk;

  int passed = 0;
  int total  = 0;

  // Model state: expected tuple stream and observation counters
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] last_tuple = '0;
  int obs[256];
  int obs_n = 0;
  int n_valid = 0, n_done = 0, n_cfg = 0, n_drain = 0;
  logic [1:0] prev_state = 2'd0;
  logic prev_cfg = 1'b0;
  int cic[4], coc[4], crow[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock; all per-cycle output comparisons against the model happen here
  task automatic tick();
    logic [TW-1:0] cur;
    logic [TW-1:0] t;
    @(negedge aclk);
    cur = {o_current_layer, o_current_oc, o_current_ic};
    if (o_valid === 1'b1) begin
      n_valid++;
      if (obs_n < 256) begin
        obs[obs_n] = int'(o_current_layer) * 4 + int'(o_current_oc) * 2 + int'(o_current_ic);
        obs_n++;
      end
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: got tuple %0h expected none at %0t", cur, $time);
      end else begin
        t = exp_q.pop_front();
        check("tuple", 32'(cur), 32'(t));
      end
      last_tuple = cur;
    end
    if (o_state == 2'd2) check("tuple_stable", 32'(cur), 32'(last_tuple));
    if (o_done === 1'b1) n_done++;
    if (o_state == 2'd3 && prev_state == 2'd2) n_drain++;
    if (o_cfg_req === 1'b1 && prev_cfg == 1'b0) n_cfg++;
    prev_state = o_state;
    prev_cfg   = o_cfg_req;
  endtask

  task automatic wait_req(input bit cfg);
    int n;
    n = 0;
    while (((cfg ? o_cfg_req : o_param_req) !== 1'b1) && n < 200) begin
      tick();
      n++;
    end
    check(cfg ? "cfg_req_wait" : "param_req_wait", 32'(cfg ? o_cfg_req : o_param_req), 1);
  endtask

  task automatic pulse_rows(input int rows);
    for (int r = 0; r < rows; r++) begin
      repeat ($urandom_range(0, 2)) tick();
      i_row_done = 1'b1;
      tick();
      i_row_done = 1'b0;
    end
  endtask

  // Full job: nested-loop model builds the tuple stream, a responder serves requests
  task automatic run_job(input int nl, input bit rnd, input int ic_l, input int oc_l,
                         input int row_l, input int pdly, input bit poke);
    int v0, d0, c0, dr0, ntup, ndrain, d;
    bit poked;
    poked = 1'b0;
    ntup = 0;
    ndrain = 0;
    exp_q.delete();
    for (int l = 0; l <= nl; l++) begin
      cic[l]  = rnd ? int'($urandom_range(0, 2)) : ic_l;
      coc[l]  = rnd ? int'($urandom_range(0, 2)) : oc_l;
      crow[l] = rnd ? int'($urandom_range(0, 3)) : row_l;
      for (int oc = 0; oc <= coc[l]; oc++)
        for (int ic = 0; ic <= cic[l]; ic++) begin
          exp_q.push_back({LW'(l), CW'(oc), CW'(ic)});
          ntup++;
        end
      ndrain += coc[l] + 1;
    end
    v0 = n_valid; d0 = n_done; c0 = n_cfg; dr0 = n_drain;

    i_num_layers = LW'(nl);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_state", 32'(o_state), 1);
    check("start_busy", 32'(o_busy), 1);
    check("start_err_clear", 32'(o_err), 0);

    for (int l = 0; l <= nl; l++) begin
      wait_req(1'b1);
      repeat ($urandom_range(0, 2)) tick();
      i_cfg_valid    = 1'b1;
      i_cfg_ic_last  = CW'(cic[l]);
      i_cfg_oc_last  = CW'(coc[l]);
      i_cfg_row_last = RW'(crow[l]);
      tick();
      i_cfg_valid = 1'b0;
      check("cfg_req_drop", 32'(o_cfg_req), 0);
      check("param_req_rise", 32'(o_param_req), 1);
      for (int oc = 0; oc <= coc[l]; oc++) begin
        for (int ic = 0; ic <= cic[l]; ic++) begin
          wait_req(1'b0);
          d = (pdly >= 0) ? pdly : int'($urandom_range(0, 3));
          for (int k = 0; k < d; k++) begin
            tick();
            check("param_req_hold", 32'(o_param_req), 1);
            check("no_early_valid", 32'(o_valid), 0);
          end
          i_params_valid = 1'b1;
          tick();
          i_params_valid = 1'b0;
          check("valid_latency", 32'(o_valid), 1);
          check("run_state", 32'(o_state), 2);
          if (poke && !poked) begin
            poked = 1'b1;
            i_num_layers = ~LW'(nl);
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
            check("start_ignored_state", 32'(o_state), 2);
            check("start_ignored_busy", 32'(o_busy), 1);
          end
          pulse_rows(crow[l] + 1);
          check("after_rows_state", 32'(o_state), (ic < cic[l]) ? 1 : 3);
        end
        repeat ($urandom_range(0, 2)) tick();
        i_send_done = 1'b1;
        tick();
        i_send_done = 1'b0;
        if (!(l == nl && oc == coc[l])) check("after_send_state", 32'(o_state), 1);
      end
    end
    check("done_pulse", 32'(o_done), 1);
    check("done_state", 32'(o_state), 3);
    tick();
    check("done_single", 32'(o_done), 0);
    check("idle_state", 32'(o_state), 0);
    check("idle_busy", 32'(o_busy), 0);
    check("valid_count", 32'(n_valid - v0), 32'(ntup));
    check("done_count", 32'(n_done - d0), 1);
    check("cfg_count", 32'(n_cfg - c0), 32'(nl + 1));
    check("drain_count", 32'(n_drain - dr0), 32'(ndrain));
    check("model_drained", 32'(exp_q.size()), 0);
    check("no_err", 32'(o_err), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(o_state), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_cfg_req"}, 32'(o_cfg_req), 0);
    check({tag, "_param_req"}, 32'(o_param_req), 0);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_tuple"}, 32'({o_current_layer, o_current_oc, o_current_ic}), 0);
  endtask

  int lit[8];
  int o0, d0;

  initial begin
    lit = '{0, 1, 2, 3, 4, 5, 6, 7};
    repeat (3) tick();
    check_all_zero("reset");
    check("reset_err", 32'(o_err), 0);
    areset = 1'b0;
    tick();

    // Single tuple, three rows
    run_job(0, 1'b0, 0, 0, 2, -1, 1'b0);

    // Two layers, 2x2 channels: literal tuple order pins the model
    o0 = obs_n;
    run_job(1, 1'b0, 1, 1, 0, -1, 1'b0);
    for (int k = 0; k < 8; k++) check("literal_order", 32'(obs[o0 + k]), 32'(lit[k]));

    // Slow parameter load
    run_job(0, 1'b0, 0, 0, 0, 20, 1'b0);

    // Abort mid-run on the second tuple
    exp_q.delete();
    exp_q.push_back({LW'(0), CW'(0), CW'(0)});
    exp_q.push_back({LW'(0), CW'(0), CW'(1)});
    i_num_layers = '0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    wait_req(1'b1);
    i_cfg_valid = 1'b1; i_cfg_ic_last = CW'(1); i_cfg_oc_last = '0; i_cfg_row_last = RW'(2);
    tick(); i_cfg_valid = 1'b0;
    wait_req(1'b0);
    i_params_valid = 1'b1; tick(); i_params_valid = 1'b0;
    pulse_rows(3);
    wait_req(1'b0);
    i_params_valid = 1'b1; tick(); i_params_valid = 1'b0;
    check("abort_pre_ic", 32'(o_current_ic), 1);
    pulse_rows(1);
    d0 = n_done;
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    check_all_zero("abort");
    repeat (5) tick();
    check("abort_no_done", 32'(n_done - d0), 0);
    run_job(0, 1'b0, 1, 1, 1, -1, 1'b0);

    // Stray row pulse in IDLE sets the sticky error; next start clears it
    i_row_done = 1'b1; tick(); i_row_done = 1'b0;
    tick();
    check("idle_row_err", 32'(o_err), 1);
    repeat (3) tick();
    check("err_sticky", 32'(o_err), 1);
    run_job(0, 1'b0, 0, 0, 0, 0, 1'b1);

    // Synchronous reset while draining
    exp_q.delete();
    exp_q.push_back({LW'(0), CW'(0), CW'(0)});
    i_num_layers = '0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    wait_req(1'b1);
    i_cfg_valid = 1'b1; i_cfg_ic_last = '0; i_cfg_oc_last = '0; i_cfg_row_last = '0;
    tick(); i_cfg_valid = 1'b0;
    wait_req(1'b0);
    i_params_valid = 1'b1; tick(); i_params_valid = 1'b0;
    pulse_rows(1);
    check("pre_reset_drain", 32'(o_state), 3);
    areset = 1'b1; tick(); areset = 1'b0;
    check_all_zero("midreset");
    check("midreset_err", 32'(o_err), 0);
    d0 = n_done;
    i_send_done = 1'b1; tick(); i_send_done = 1'b0;
    tick();
    check("late_send_err", 32'(o_err), 1);
    check("late_send_state", 32'(o_state), 0);
    check("late_send_no_done", 32'(n_done - d0), 0);

    // Randomized jobs, one with an ignored start mid-run
    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(0, 3)), 1'b1, 0, 0, 0, -1, (j == 2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
